cvxif_coproc_router: RTL and testbench



---
 rtl/cvxif_coproc_router.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cvxif_coproc_router.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_coproc_router.sv
// CV-X-IF router: fans one core port out to NrCoproc coprocessors, records which
// coprocessor owns each in-flight id, and round-robin arbitrates results back.

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned NrRgprPorts;
        int unsigned TRANS_ID_BITS;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, NrRgprPorts: 2, TRANS_ID_BITS: 2};
endpackage

package cvxif_pkg;
    localparam int unsigned XLEN = config_pkg::cva6_cfg_empty.XLEN;
    localparam int unsigned NR_RS = config_pkg::cva6_cfg_empty.NrRgprPorts;
    localparam int unsigned ID_W = config_pkg::cva6_cfg_empty.TRANS_ID_BITS;

    typedef struct packed {
        logic [15:0] instr;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [ID_W-1:0] id;
    } x_issue_req_t;

    typedef struct packed {
        logic             accept;
        logic             writeback;
        logic [NR_RS-1:0] register_read;
    } x_issue_resp_t;

    typedef struct packed {
        logic [ID_W-1:0]             id;
        logic [NR_RS-1:0][XLEN-1:0] rs;
        logic [NR_RS-1:0]            rs_valid;
    } x_register_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
    } x_result_t;

    typedef struct packed {
        logic              compressed_valid;
        x_compressed_req_t compressed_req;
        logic              issue_valid;
        x_issue_req_t      issue_req;
        logic              register_valid;
        x_register_t       register;
        logic              commit_valid;
        x_commit_t         commit;
        logic              result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               compressed_ready;
        x_compressed_resp_t compressed_resp;
        logic               issue_ready;
        x_issue_resp_t      issue_resp;
        logic               register_ready;
        logic               result_valid;
        x_result_t          result;
    } cvxif_resp_t;
endpackage

module cvxif_coproc_router #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NrCoproc = 2,
    parameter int unsigned NrIds = 4,
    parameter type cvxif_req_t = cvxif_pkg::cvxif_req_t,
    parameter type cvxif_resp_t = cvxif_pkg::cvxif_resp_t
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  cvxif_req_t       cvxif_req_i,
    output cvxif_resp_t      cvxif_resp_o,
    output cvxif_req_t       cvxif_req_o [NrCoproc],
    input  cvxif_resp_t      cvxif_resp_i [NrCoproc],
    output logic             err_o,
    output logic [NrIds-1:0] busy_o
);

    localparam int unsigned IdW = CVA6Cfg.TRANS_ID_BITS;
    localparam int unsigned OwnW = (NrCoproc > 1) ? $clog2(NrCoproc) : 1;

    logic [NrIds-1:0] valid_q;
    logic [NrIds-1:0] nacc_q;
    logic [OwnW-1:0]  owner_q [NrIds];
    logic [OwnW-1:0]  rr_q;
    logic [OwnW-1:0]  grant_q;
    logic             lock_q;
    logic             err_q;

    logic [IdW-1:0]      issue_id;
    logic [IdW-1:0]      commit_id;
    logic [IdW-1:0]      res_id;
    logic [NrCoproc-1:0] comp_rdy;
    logic [NrCoproc-1:0] issue_rdy;
    logic [NrCoproc-1:0] reg_rdy;
    logic [NrCoproc-1:0] res_valid;
    logic [OwnW-1:0]     issue_win;
    logic [OwnW-1:0]     grant;
    logic [OwnW-1:0]     cand;
    logic [OwnW-1:0]     rr_next;
    logic                issue_acc;
    logic                core_issue_ready;
    logic                issue_hs;
    logic                res_any;
    logic                res_legit;
    logic                res_fwd;
    logic                res_sink;
    logic                res_hs;
    logic                err_set;

    assign issue_id  = cvxif_req_i.issue_req.id;
    assign commit_id = cvxif_req_i.commit.id;

    always_comb begin
        comp_rdy  = '0;
        issue_rdy = '0;
        reg_rdy   = '0;
        res_valid = '0;
        for (int k = 0; k < NrCoproc; k++) begin
            comp_rdy[k]  = cvxif_resp_i[k].compressed_ready;
            issue_rdy[k] = cvxif_resp_i[k].issue_ready;
            reg_rdy[k]   = cvxif_resp_i[k].register_ready;
            res_valid[k] = cvxif_resp_i[k].result_valid;
        end
    end

    // Walking downwards lets the lowest-index acceptor win the issue ownership.
    always_comb begin
        issue_win = '0;
        issue_acc = 1'b0;
        for (int k = NrCoproc - 1; k >= 0; k--) begin
            if (cvxif_resp_i[k].issue_resp.accept) begin
                issue_win = OwnW'(k);
                issue_acc = 1'b1;
            end
        end
    end

    assign core_issue_ready = !valid_q[issue_id] && (&issue_rdy);
    assign issue_hs         = cvxif_req_i.issue_valid && core_issue_ready;

    // A held grant stays put until the core takes the result; otherwise the
    // first requester at or after the RR pointer wins.
    always_comb begin
        grant   = rr_q;
        cand    = '0;
        res_any = 1'b0;
        if (lock_q) begin
            grant   = grant_q;
            res_any = res_valid[grant_q];
        end else begin
            for (int i = NrCoproc - 1; i >= 0; i--) begin
                cand = OwnW'((int'(rr_q) + i) % int'(NrCoproc));
                if (res_valid[cand]) begin
                    grant   = cand;
                    res_any = 1'b1;
                end
            end
        end
    end

    assign res_id    = cvxif_resp_i[grant].result.id;
    assign res_legit = valid_q[res_id] && (owner_q[res_id] == grant);
    assign res_fwd   = res_any && res_legit;
    assign res_sink  = res_any && !res_legit;
    assign res_hs    = res_fwd && cvxif_req_i.result_ready;
    assign rr_next   = (grant == OwnW'(NrCoproc - 1)) ? '0 : grant + OwnW'(1);

    assign err_set = (cvxif_req_i.commit_valid && !valid_q[commit_id] && !nacc_q[commit_id])
                  || (cvxif_req_i.commit_valid && cvxif_req_i.issue_valid && (commit_id == issue_id))
                  || res_sink;

    always_comb begin
        for (int k = 0; k < NrCoproc; k++) begin
            cvxif_req_o[k] = cvxif_req_i;
            cvxif_req_o[k].issue_valid = cvxif_req_i.issue_valid && !valid_q[issue_id];
            cvxif_req_o[k].commit.commit_kill = cvxif_req_i.commit.commit_kill
                || !(valid_q[commit_id] && (owner_q[commit_id] == OwnW'(k)));
            cvxif_req_o[k].result_ready = (grant == OwnW'(k))
                && (res_sink || (res_fwd && cvxif_req_i.result_ready));
        end
    end

    always_comb begin
        cvxif_resp_o = '0;
        cvxif_resp_o.compressed_ready = &comp_rdy;
        cvxif_resp_o.issue_ready      = core_issue_ready;
        cvxif_resp_o.register_ready   = &reg_rdy;
        for (int k = NrCoproc - 1; k >= 0; k--) begin
            if (cvxif_resp_i[k].compressed_resp.accept) begin
                cvxif_resp_o.compressed_resp = cvxif_resp_i[k].compressed_resp;
            end
            if (cvxif_resp_i[k].issue_resp.accept) begin
                cvxif_resp_o.issue_resp = cvxif_resp_i[k].issue_resp;
            end
        end
        if (res_fwd) begin
            cvxif_resp_o.result_valid = 1'b1;
            cvxif_resp_o.result       = cvxif_resp_i[grant].result;
        end
    end

    // Clears are written before sets: an issuing id is never valid, so it
    // cannot collide with a result or kill retiring the same entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            nacc_q  <= '0;
            for (int i = 0; i < NrIds; i++) begin
                owner_q[i] <= '0;
            end
            rr_q    <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (cvxif_req_i.commit_valid) begin
                nacc_q[commit_id] <= 1'b0;
                if (cvxif_req_i.commit.commit_kill) begin
                    valid_q[commit_id] <= 1'b0;
                end
            end
            if (res_hs) begin
                valid_q[res_id] <= 1'b0;
            end
            if (issue_hs && issue_acc) begin
                valid_q[issue_id] <= 1'b1;
                owner_q[issue_id] <= issue_win;
                nacc_q[issue_id]  <= 1'b0;
            end else if (issue_hs) begin
                nacc_q[issue_id] <= 1'b1;
            end
            if (res_hs || res_sink) begin
                rr_q <= rr_next;
            end
            lock_q  <= res_fwd && !cvxif_req_i.result_ready;
            grant_q <= grant;
            err_q   <= err_q || err_set;
        end
    end

    assign busy_o = valid_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_cvxif_coproc_router.sv
// Directed bench for cvxif_coproc_router with two bench-modelled coprocessors
// and hand-computed expectations for ownership, steering and arbitration.

module tb_cvxif_coproc_router;

    logic clk_i;
    logic rst_i;
    cvxif_pkg::cvxif_req_t  core_req;
    cvxif_pkg::cvxif_resp_t core_resp;
    cvxif_pkg::cvxif_req_t  cp_req [2];
    cvxif_pkg::cvxif_resp_t cp_resp [2];
    logic                   err_o;
    logic [3:0]             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    cvxif_coproc_router #(
        .NrCoproc(2),
        .NrIds   (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cvxif_req_i (core_req),
        .cvxif_resp_o(core_resp),
        .cvxif_req_o (cp_req),
        .cvxif_resp_i(cp_resp),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, then give the new inputs time to be driven.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic clear_stim();
        core_req = '0;
        for (int k = 0; k < 2; k++) begin
            cp_resp[k] = '0;
            cp_resp[k].compressed_ready = 1'b1;
            cp_resp[k].issue_ready      = 1'b1;
            cp_resp[k].register_ready   = 1'b1;
        end
    endtask

    task automatic do_reset();
        clear_stim();
        rst_i = 1'b1;
        applyStimulus(2);
        rst_i = 1'b0;
        #1;
    endtask

    task automatic issue_one(input logic [1:0] id, input logic acc0, input logic acc1);
        core_req.issue_valid        = 1'b1;
        core_req.issue_req.id       = id;
        core_req.issue_req.instr    = 32'h0000_500b;
        cp_resp[0].issue_resp.accept = acc0;
        cp_resp[1].issue_resp.accept = acc1;
        applyStimulus(1);
        core_req.issue_valid         = 1'b0;
        cp_resp[0].issue_resp.accept = 1'b0;
        cp_resp[1].issue_resp.accept = 1'b0;
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        clear_stim();
        applyStimulus(1);
        do_reset();

        // Reset state and ready combining
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_result_valid", core_resp.result_valid, 0);
        checkOutput("rst_issue_ready", core_resp.issue_ready, 1);
        checkOutput("rst_comp_resp", core_resp.compressed_resp, 0);
        cp_resp[1].compressed_ready = 1'b0;
        #1;
        checkOutput("comp_ready_and", core_resp.compressed_ready, 0);
        cp_resp[1].compressed_ready = 1'b1;

        // Compressed response selection
        core_req.compressed_valid = 1'b1;
        cp_resp[0].compressed_resp.instr = 32'h0000_aaaa;
        cp_resp[1].compressed_resp.instr = 32'h1111_2222;
        cp_resp[1].compressed_resp.accept = 1'b1;
        #1;
        checkOutput("comp_cp1_only", core_resp.compressed_resp.instr, 32'h1111_2222);
        checkOutput("comp_bcast", cp_req[0].compressed_valid, 1);
        cp_resp[0].compressed_resp.accept = 1'b1;
        #1;
        checkOutput("comp_both", core_resp.compressed_resp.instr, 32'h0000_aaaa);
        clear_stim();

        // Issue id 2 accepted only by cp1, commit, result
        core_req.issue_valid     = 1'b1;
        core_req.issue_req.id    = 2'd2;
        cp_resp[1].issue_resp.accept    = 1'b1;
        cp_resp[1].issue_resp.writeback = 1'b1;
        #1;
        checkOutput("t1_issue_ready", core_resp.issue_ready, 1);
        checkOutput("t1_issue_wb", core_resp.issue_resp.writeback, 1);
        checkOutput("t1_cp0_issue_valid", cp_req[0].issue_valid, 1);
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t1_busy", busy_o, 4'b0100);
        core_req.commit_valid = 1'b1;
        core_req.commit.id    = 2'd2;
        #1;
        checkOutput("t1_cp0_kill", cp_req[0].commit.commit_kill, 1);
        checkOutput("t1_cp1_kill", cp_req[1].commit.commit_kill, 0);
        applyStimulus(1);
        core_req.commit_valid = 1'b0;
        #1;
        checkOutput("t1_busy_after_commit", busy_o, 4'b0100);
        cp_resp[1].result_valid = 1'b1;
        cp_resp[1].result.id    = 2'd2;
        cp_resp[1].result.data  = 32'hdead_beef;
        core_req.result_ready   = 1'b1;
        #1;
        checkOutput("t1_res_valid", core_resp.result_valid, 1);
        checkOutput("t1_res_data", core_resp.result.data, 32'hdead_beef);
        checkOutput("t1_cp1_res_ready", cp_req[1].result_ready, 1);
        checkOutput("t1_cp0_res_ready", cp_req[0].result_ready, 0);
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t1_busy_free", busy_o, 0);
        checkOutput("t1_err", err_o, 0);

        // Dual accept of id 1: cp0 owns it
        core_req.issue_valid  = 1'b1;
        core_req.issue_req.id = 2'd1;
        cp_resp[0].issue_resp.accept    = 1'b1;
        cp_resp[1].issue_resp.accept    = 1'b1;
        cp_resp[1].issue_resp.writeback = 1'b1;
        #1;
        checkOutput("t2_issue_wb_cp0", core_resp.issue_resp.writeback, 0);
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t2_busy", busy_o, 4'b0010);
        core_req.commit_valid = 1'b1;
        core_req.commit.id    = 2'd1;
        #1;
        checkOutput("t2_cp0_kill", cp_req[0].commit.commit_kill, 0);
        checkOutput("t2_cp1_kill", cp_req[1].commit.commit_kill, 1);
        applyStimulus(1);
        core_req.commit.commit_kill = 1'b1;
        #1;
        checkOutput("t2_kill_cp0", cp_req[0].commit.commit_kill, 1);
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t2_busy_killed", busy_o, 0);
        checkOutput("t2_err", err_o, 0);

        // Result contention: cp0 owns id 0, cp1 owns id 3
        issue_one(2'd0, 1'b1, 1'b0);
        issue_one(2'd3, 1'b0, 1'b1);
        checkOutput("t3_busy", busy_o, 4'b1001);
        cp_resp[0].result_valid = 1'b1;
        cp_resp[0].result.id    = 2'd0;
        cp_resp[0].result.data  = 32'h0000_00a0;
        cp_resp[1].result_valid = 1'b1;
        cp_resp[1].result.id    = 2'd3;
        cp_resp[1].result.data  = 32'h0000_00b3;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("t3_hold_data", core_resp.result.data, 32'h0000_00a0);
            checkOutput("t3_hold_cp0_ready", cp_req[0].result_ready, 0);
            applyStimulus(1);
        end
        core_req.result_ready = 1'b1;
        #1;
        checkOutput("t3_cp0_data", core_resp.result.data, 32'h0000_00a0);
        checkOutput("t3_cp0_ready", cp_req[0].result_ready, 1);
        checkOutput("t3_cp1_wait", cp_req[1].result_ready, 0);
        applyStimulus(1);
        cp_resp[0].result_valid = 1'b0;
        #1;
        checkOutput("t3_cp1_data", core_resp.result.data, 32'h0000_00b3);
        checkOutput("t3_cp1_ready", cp_req[1].result_ready, 1);
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t3_busy_free", busy_o, 0);

        // Unknown-id results are sunk; grant order shows RR pointer back at 0
        cp_resp[0].result_valid = 1'b1;
        cp_resp[0].result.id    = 2'd2;
        cp_resp[1].result_valid = 1'b1;
        cp_resp[1].result.id    = 2'd3;
        #1;
        checkOutput("t5_cp0_sunk", cp_req[0].result_ready, 1);
        checkOutput("t5_cp1_wait", cp_req[1].result_ready, 0);
        checkOutput("t5_not_fwd", core_resp.result_valid, 0);
        applyStimulus(1);
        cp_resp[0].result_valid = 1'b0;
        #1;
        checkOutput("t5_cp1_sunk", cp_req[1].result_ready, 1);
        checkOutput("t5_not_fwd2", core_resp.result_valid, 0);
        checkOutput("t5_err", err_o, 1);
        applyStimulus(1);
        cp_resp[1].result_valid = 1'b0;
        applyStimulus(1);
        checkOutput("t5_err_sticky", err_o, 1);

        // Reset mid-instruction
        issue_one(2'd2, 1'b0, 1'b1);
        checkOutput("t6_busy_pre", busy_o, 4'b0100);
        do_reset();
        checkOutput("t6_busy_rst", busy_o, 0);
        checkOutput("t6_err_rst", err_o, 0);

        // Busy id blocks issue until the result frees it
        issue_one(2'd0, 1'b1, 1'b0);
        core_req.issue_valid  = 1'b1;
        core_req.issue_req.id = 2'd0;
        cp_resp[1].issue_resp.accept = 1'b1;
        #1;
        checkOutput("t4_issue_blocked", core_resp.issue_ready, 0);
        checkOutput("t4_cp0_no_valid", cp_req[0].issue_valid, 0);
        checkOutput("t4_cp1_no_valid", cp_req[1].issue_valid, 0);
        applyStimulus(1);
        cp_resp[0].result_valid = 1'b1;
        cp_resp[0].result.id    = 2'd0;
        core_req.result_ready   = 1'b1;
        #1;
        checkOutput("t4_res_fwd", core_resp.result_valid, 1);
        checkOutput("t4_freeing_blocked", core_resp.issue_ready, 0);
        applyStimulus(1);
        cp_resp[0].result_valid = 1'b0;
        #1;
        checkOutput("t4_issue_ready_n1", core_resp.issue_ready, 1);
        checkOutput("t4_cp1_valid_n1", cp_req[1].issue_valid, 1);
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t4_busy_cp1", busy_o, 4'b0001);
        core_req.commit_valid = 1'b1;
        core_req.commit.id    = 2'd0;
        #1;
        checkOutput("t4_cp0_kill", cp_req[0].commit.commit_kill, 1);
        checkOutput("t4_cp1_kill", cp_req[1].commit.commit_kill, 0);
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t4_err", err_o, 0);

        // Non-accepted instruction may be committed without error
        issue_one(2'd3, 1'b0, 1'b0);
        checkOutput("t7_busy_nacc", busy_o, 4'b0001);
        core_req.commit_valid = 1'b1;
        core_req.commit.id    = 2'd3;
        applyStimulus(1);
        core_req.commit_valid = 1'b0;
        #1;
        checkOutput("t7_nacc_no_err", err_o, 0);
        core_req.commit_valid = 1'b1;
        core_req.commit.id    = 2'd1;
        applyStimulus(1);
        core_req.commit_valid = 1'b0;
        #1;
        checkOutput("t7_commit_unknown_err", err_o, 1);

        // Issue and commit of the same id in one cycle
        do_reset();
        issue_one(2'd2, 1'b0, 1'b0);
        checkOutput("t8_err_pre", err_o, 0);
        core_req.issue_valid  = 1'b1;
        core_req.issue_req.id = 2'd2;
        core_req.commit_valid = 1'b1;
        core_req.commit.id    = 2'd2;
        applyStimulus(1);
        clear_stim();
        #1;
        checkOutput("t8_same_id_err", err_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
